// File: rtl/fp_addsub_arbiter.sv
// fp_addsub_arbiter: round-robin arbiter sharing one fixed-latency pipelined FP add/sub unit
//
// Requesters present operands with valid/ready.
// One grant is made per cycle, and the granted operands are driven straight to the unit.
// A tag pipe, as long as the unit latency, remembers who issued each op.
// The unit output is registered and returned with that requester ID.
// Per-requester credit counters cap the number of ops in flight.
//
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset (also resets the shared unit)
//   i_req_valid        per-requester request valid
//   o_req_ready        per-requester grant, one-hot or zero
//   i_req_a/i_req_b    packed operands, slice i belongs to requester i
//   i_req_op           per-requester operation, 0 = add, 1 = subtract
//   o_fpu_a/b/op       operands and operation to the shared unit (zero when idle)
//   i_fpu_result/flags unit outputs, valid LATENCY cycles after issue
//   o_resp_valid       one-cycle response strobe
//   o_resp_id          ID of the requester that the response belongs to
//   o_resp_result      registered unit result
//   o_resp_flags       registered unit flags
//   o_busy             any op in flight or a response being presented
//
// Configuration macro: FPAS_ARB_PRIORITY_EN
//   When defined, requester 0 wins whenever eligible and does not move the pointer.
//   Requesters 1..NUM_REQ-1 share round-robin among themselves.
module fp_addsub_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DWIDTH  = 16,
    parameter int LATENCY = 9,
    parameter int MAX_OUT = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [NUM_REQ-1:0]           i_req_valid,
    output logic [NUM_REQ-1:0]           o_req_ready,
    input  logic [NUM_REQ*DWIDTH-1:0]    i_req_a,
    input  logic [NUM_REQ*DWIDTH-1:0]    i_req_b,
    input  logic [NUM_REQ-1:0]           i_req_op,
    output logic [DWIDTH-1:0]            o_fpu_a,
    output logic [DWIDTH-1:0]            o_fpu_b,
    output logic                         o_fpu_op,
    input  logic [DWIDTH-1:0]            i_fpu_result,
    input  logic [4:0]                   i_fpu_flags,
    output logic                         o_resp_valid,
    output logic [$clog2(NUM_REQ)-1:0]   o_resp_id,
    output logic [DWIDTH-1:0]            o_resp_result,
    output logic [4:0]                   o_resp_flags,
    output logic                         o_busy
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(MAX_OUT + 1);

    logic [NUM_REQ-1:0] w_elig;
    logic [NUM_REQ-1:0] w_rr_elig;
    logic               w_gnt_any;
    logic [IDW-1:0]     w_gnt_id;
    logic               w_move;
    logic [IDW-1:0]     r_ptr;
    logic [LATENCY-1:0] r_tag_v;
    logic [IDW-1:0]     r_tag_id [LATENCY];
    logic               r_resp_valid;
    logic [IDW-1:0]     r_resp_id;
    logic [DWIDTH-1:0]  r_resp_result;
    logic [4:0]         r_resp_flags;

`ifdef FPAS_ARB_PRIORITY_EN
    assign w_rr_elig = w_elig & ~NUM_REQ'(1);
    assign w_move    = w_gnt_any && !w_elig[0];
`else
    assign w_rr_elig = w_elig;
    assign w_move    = w_gnt_any;
`endif

    // Scan from farthest to nearest so the last hit is the first eligible index after r_ptr.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_id  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (w_rr_elig[IDW'((int'(r_ptr) + k) % NUM_REQ)]) begin
                w_gnt_any = 1'b1;
                w_gnt_id  = IDW'((int'(r_ptr) + k) % NUM_REQ);
            end
        end
`ifdef FPAS_ARB_PRIORITY_EN
        if (w_elig[0]) begin
            w_gnt_any = 1'b1;
            w_gnt_id  = '0;
        end
`endif
    end

    assign o_req_ready = w_gnt_any ? NUM_REQ'(1) << w_gnt_id : '0;
    assign o_fpu_a     = w_gnt_any ? i_req_a[w_gnt_id*DWIDTH +: DWIDTH] : '0;
    assign o_fpu_b     = w_gnt_any ? i_req_b[w_gnt_id*DWIDTH +: DWIDTH] : '0;
    assign o_fpu_op    = w_gnt_any && i_req_op[w_gnt_id];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_credit
        logic [CW-1:0] r_cnt;
        logic          w_inc;
        logic          w_dec;
        assign w_inc     = w_gnt_any && (w_gnt_id == IDW'(g));
        assign w_dec     = r_tag_v[LATENCY-1] && (r_tag_id[LATENCY-1] == IDW'(g));
        assign w_elig[g] = i_req_valid[g] && (r_cnt < CW'(MAX_OUT));
        always_ff @(posedge i_clk) begin
            if (i_rst)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + CW'(w_inc) - CW'(w_dec);
        end
        always_ff @(posedge i_clk) begin
            if (!i_rst) begin
                assert (!(w_inc && !w_dec && r_cnt >= CW'(MAX_OUT)))
                    else $error("credit overflow on requester %0d", g);
                assert (!(w_dec && !w_inc && r_cnt == '0))
                    else $error("credit underflow on requester %0d", g);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr         <= IDW'(NUM_REQ - 1);
            r_tag_v       <= '0;
            r_resp_valid  <= 1'b0;
            r_resp_id     <= '0;
            r_resp_result <= '0;
            r_resp_flags  <= '0;
        end else begin
            r_tag_v      <= {r_tag_v[LATENCY-2:0], w_gnt_any};
            r_resp_valid <= r_tag_v[LATENCY-1];
            if (w_move)
                r_ptr <= w_gnt_id;
            // Unit output is only meaningful under a valid tag; otherwise hold the last response.
            if (r_tag_v[LATENCY-1]) begin
                r_resp_id     <= r_tag_id[LATENCY-1];
                r_resp_result <= i_fpu_result;
                r_resp_flags  <= i_fpu_flags;
            end
        end
    end

    // IDs need no reset: they are qualified by r_tag_v.
    always_ff @(posedge i_clk) begin
        r_tag_id[0] <= w_gnt_id;
        for (int j = 1; j < LATENCY; j++)
            r_tag_id[j] <= r_tag_id[j-1];
    end

    assign o_resp_valid  = r_resp_valid;
    assign o_resp_id     = r_resp_id;
    assign o_resp_result = r_resp_result;
    assign o_resp_flags  = r_resp_flags;
    assign o_busy        = (|r_tag_v) | r_resp_valid;
endmodule
